toggle_activity_monitor: RTL

Switching-activity monitor that sits directly downstream of a combinational benchmark netlist under power evaluation. It consumes the netlist's output vector as a valid/ready stream and computes the Hamming distance between consecutive samples. It accumulates total and peak toggles over a fixed window of transitions, then emits one report record per window. The reward/measurement logic of the power-aware synthesis flow reads these reports.

---
 rtl/toggle_activity_monitor.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/toggle_activity_monitor.sv
// toggle_activity_monitor: measures switching activity of an upstream netlist.
// Accepts the output vector as a valid/ready stream, computes the Hamming
// distance between consecutive samples, and reports the total (saturating) and
// peak toggle count once every WIN transitions.
// Optional feature macro: PER_BIT_TOGGLE_EN adds per-bit toggle counters
// reported on rpt_bit_cnt (field i = toggles of in_vec[i]).
module toggle_activity_monitor #(
  parameter int W     = 14,
  parameter int WIN   = 256,
  parameter int CNT_W = 24,
  localparam int PW   = $clog2(W + 1),
  localparam int BW   = $clog2(WIN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_vec,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [CNT_W-1:0]  rpt_total,
  output logic [PW-1:0]     rpt_peak,
  output logic [15:0]       rpt_win_id
`ifdef PER_BIT_TOGGLE_EN
  ,
  output logic [W*BW-1:0]   rpt_bit_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [BW-1:0]    WIN_LAST = BW'(WIN);
  localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       prev;
  logic [CNT_W-1:0]   acc;
  logic [PW-1:0]      peak;
  logic [BW-1:0]      cnt;
  logic [15:0]        win_id;

  logic               accept;
  logic               last_trans;
  logic [W-1:0]       diff;
  logic [PW-1:0]      hd;
  logic [CNT_W:0]     acc_sum;
  logic [CNT_W-1:0]   acc_nxt;
  logic [PW-1:0]      peak_nxt;
  logic [BW-1:0]      cnt_inc;

  // Number of set bits in a vector (Hamming weight).
  function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
    logic [PW-1:0] s;
    s = {PW{1'b0}};
    for (int i = 0; i < W; i++) begin
      s = s + PW'(v[i]);
    end
    return s;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr forces EMPTY and discards any pending report.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (accept) state_nxt = ST_RUN;
        else        state_nxt = ST_EMPTY;
      end
      ST_RUN: begin
        if (accept && last_trans) state_nxt = ST_REPORT;
        else                      state_nxt = ST_RUN;
      end
      ST_REPORT: begin
        if (rpt_ready) state_nxt = ST_RUN;
        else           state_nxt = ST_REPORT;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (clr) state_nxt = ST_EMPTY;
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    rpt_valid = 1'b0;
    case (state)
      ST_EMPTY:  in_ready = ~rst;
      ST_RUN:    in_ready = ~rst;
      ST_REPORT: rpt_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        rpt_valid = 1'b0;
      end
    endcase
  end

  // Per-transition arithmetic: Hamming distance, saturating sum, running max.
  always_comb begin
    accept     = in_valid & in_ready & ~clr;
    diff       = in_vec ^ prev;
    hd         = popcount(diff);
    acc_sum    = {1'b0, acc} + {{(CNT_W + 1 - PW){1'b0}}, hd};
    if (acc_sum[CNT_W]) acc_nxt = ACC_MAX;
    else                acc_nxt = acc_sum[CNT_W-1:0];
    if (hd > peak) peak_nxt = hd;
    else           peak_nxt = peak;
    cnt_inc    = cnt + {{(BW - 1){1'b0}}, 1'b1};
    last_trans = (cnt_inc == WIN_LAST);
  end

  // Window accumulators and registered report fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= {W{1'b0}};
      acc        <= {CNT_W{1'b0}};
      peak       <= {PW{1'b0}};
      cnt        <= {BW{1'b0}};
      win_id     <= 16'd0;
      rpt_total  <= {CNT_W{1'b0}};
      rpt_peak   <= {PW{1'b0}};
      rpt_win_id <= 16'd0;
    end else if (clr) begin
      acc  <= {CNT_W{1'b0}};
      peak <= {PW{1'b0}};
      cnt  <= {BW{1'b0}};
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) prev <= in_vec;
        end
        ST_RUN: begin
          if (accept) begin
            prev <= in_vec;
            acc  <= acc_nxt;
            peak <= peak_nxt;
            cnt  <= cnt_inc;
            if (last_trans) begin
              rpt_total  <= acc_nxt;
              rpt_peak   <= peak_nxt;
              rpt_win_id <= win_id;
            end
          end
        end
        ST_REPORT: begin
          if (rpt_ready) begin
            acc    <= {CNT_W{1'b0}};
            peak   <= {PW{1'b0}};
            cnt    <= {BW{1'b0}};
            win_id <= win_id + 16'd1;
          end
        end
        default: begin
          acc  <= {CNT_W{1'b0}};
          peak <= {PW{1'b0}};
          cnt  <= {BW{1'b0}};
        end
      endcase
    end
  end

`ifdef PER_BIT_TOGGLE_EN
  logic [BW-1:0] bit_cnt     [W];
  logic [BW-1:0] bit_cnt_nxt [W];

  // Per-bit counts including the transition being accepted this cycle.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      bit_cnt_nxt[i] = bit_cnt[i] + BW'(diff[i]);
    end
  end

  // Per-bit toggle counters, cleared alongside the window accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < W; i++) bit_cnt[i] <= {BW{1'b0}};
      rpt_bit_cnt <= {(W * BW){1'b0}};
    end else if (clr) begin
      for (int i = 0; i < W; i++) bit_cnt[i] <= {BW{1'b0}};
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            for (int i = 0; i < W; i++) bit_cnt[i] <= bit_cnt_nxt[i];
            if (last_trans) begin
              for (int i = 0; i < W; i++) rpt_bit_cnt[i*BW +: BW] <= bit_cnt_nxt[i];
            end
          end
        end
        ST_REPORT: begin
          if (rpt_ready) begin
            for (int i = 0; i < W; i++) bit_cnt[i] <= {BW{1'b0}};
          end
        end
        default: begin
          for (int i = 0; i < W; i++) bit_cnt[i] <= bit_cnt[i];
        end
      endcase
    end
  end
`endif

endmodule
